// File: rtl/mjpg_ereq_scheduler_if.sv
// rtl/mjpg_ereq_scheduler_if.sv - row timing inputs and encoder slot outputs of the ereq scheduler
interface mjpg_ereq_scheduler_if #(
    parameter int XW = 8
);
    logic          frame_start;
    logic          hdr_busy;
    logic          row_start;
    logic [XW-1:0] h_mcu;
    logic [2:0]    ereq;
    logic [XW-1:0] ex_y;
    logic [XW-1:0] ex_cb;
    logic [XW-1:0] ex_cr;
    logic          busy;
    logic          row_done;
    logic          err_overrun;

    modport master (
        output frame_start, hdr_busy, row_start, h_mcu,
        input  ereq, ex_y, ex_cb, ex_cr, busy, row_done, err_overrun
    );

    modport slave (
        input  frame_start, hdr_busy, row_start, h_mcu,
        output ereq, ex_y, ex_cb, ex_cr, busy, row_done, err_overrun
    );
endinterface

// File: rtl/mjpg_ereq_scheduler.sv
// rtl/mjpg_ereq_scheduler.sv - per-MCU-row Y/Cb/Cr slot grant sequencer
module mjpg_ereq_scheduler #(
    parameter int TH_Y  = 28,
    parameter int TH_C  = 6,
    parameter int GUARD = 8,
    parameter int XW    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mjpg_ereq_scheduler_if.slave  bus
);
    localparam int MAXT_YC = (TH_Y > TH_C) ? TH_Y : TH_C;
    localparam int MAXT    = (MAXT_YC > GUARD) ? MAXT_YC : GUARD;
    localparam int CW      = $clog2(MAXT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_Y,
        ST_CB,
        ST_CR,
        ST_GUARD,
        ST_DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [XW-1:0] hm_q;
    logic [2:0]    ereq_q;
    logic [XW-1:0] ex_y_q;
    logic [XW-1:0] ex_cb_q;
    logic [XW-1:0] ex_cr_q;
    logic          busy_q;
    logic          row_done_q;
    logic          err_q;

    logic          granting;
    assign granting = (state_q == ST_Y) || (state_q == ST_CB) || (state_q == ST_CR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hm_q       <= '0;
            ereq_q     <= 3'b000;
            ex_y_q     <= '0;
            ex_cb_q    <= '0;
            ex_cr_q    <= '0;
            busy_q     <= 1'b0;
            row_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            row_done_q <= 1'b0;
            cnt_q      <= cnt_q + CW'(1);

            // Overruns are flagged but never stall or reorder the grant schedule.
            if (busy_q && row_start_or_hdr_err(bus.row_start, bus.hdr_busy, granting)) begin
                err_q <= 1'b1;
            end

            if (busy_q && bus.frame_start) begin
                err_q   <= 1'b1;
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                ereq_q  <= 3'b000;
                ex_y_q  <= '0;
                ex_cb_q <= '0;
                ex_cr_q <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cnt_q <= '0;
                        if (bus.row_start && !bus.frame_start) begin
                            hm_q <= bus.h_mcu;
                            if (bus.h_mcu == '0) begin
                                state_q    <= ST_DONE;
                                row_done_q <= 1'b1;
                            end else if (bus.hdr_busy) begin
                                state_q <= ST_PEND;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= ST_Y;
                                busy_q  <= 1'b1;
                                ereq_q  <= 3'b001;
                            end
                        end
                    end
                    ST_PEND: begin
                        cnt_q <= '0;
                        if (!bus.hdr_busy) begin
                            state_q <= ST_Y;
                            ereq_q  <= 3'b001;
                        end
                    end
                    ST_Y: begin
                        if (cnt_q == CW'(TH_Y - 1)) begin
                            state_q <= ST_CB;
                            cnt_q   <= '0;
                            ereq_q  <= 3'b010;
                            ex_y_q  <= ex_y_q + XW'(1);
                        end
                    end
                    ST_CB: begin
                        if (cnt_q == CW'(TH_C - 1)) begin
                            state_q <= ST_CR;
                            cnt_q   <= '0;
                            ereq_q  <= 3'b100;
                            ex_cb_q <= ex_cb_q + XW'(1);
                        end
                    end
                    ST_CR: begin
                        if (cnt_q == CW'(TH_C - 1)) begin
                            state_q <= ST_GUARD;
                            cnt_q   <= '0;
                            ereq_q  <= 3'b000;
                            ex_cr_q <= ex_cr_q + XW'(1);
                        end
                    end
                    ST_GUARD: begin
                        if (cnt_q == CW'(GUARD - 1)) begin
                            cnt_q <= '0;
                            // ex_cr already counts the MCU just finished, so hm=2^XW-1 ends without wrap.
                            if (ex_cr_q >= hm_q) begin
                                state_q    <= ST_DONE;
                                row_done_q <= 1'b1;
                                busy_q     <= 1'b0;
                            end else begin
                                state_q <= ST_Y;
                                ereq_q  <= 3'b001;
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        ex_y_q  <= '0;
                        ex_cb_q <= '0;
                        ex_cr_q <= '0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        ereq_q  <= 3'b000;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    function automatic logic row_start_or_hdr_err(input logic rs, input logic hb, input logic gr);
        return rs || (hb && gr);
    endfunction

    assign bus.ereq        = ereq_q;
    assign bus.ex_y        = ex_y_q;
    assign bus.ex_cb       = ex_cb_q;
    assign bus.ex_cr       = ex_cr_q;
    assign bus.busy        = busy_q;
    assign bus.row_done    = row_done_q;
    assign bus.err_overrun = err_q;
endmodule

// File: tb/tb_mjpg_ereq_scheduler.sv
// tb/tb_mjpg_ereq_scheduler.sv - self-checking bench for mjpg_ereq_scheduler
module tb_mjpg_ereq_scheduler;
    localparam int TH_Y  = 28;
    localparam int TH_C  = 6;
    localparam int GUARD = 8;
    localparam int XW    = 8;
    localparam int P     = TH_Y + 2 * TH_C + GUARD;

    typedef struct {
        int h;
        int hold;
        int done_off;
    } vec_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    logic err_exp;
    int   done_q[$];
    vec_t tbl[5];

    mjpg_ereq_scheduler_if #(.XW(XW)) bus ();

    mjpg_ereq_scheduler #(
        .TH_Y (TH_Y),
        .TH_C (TH_C),
        .GUARD(GUARD),
        .XW   (XW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr();
        bus.frame_start = 1'b0;
        bus.hdr_busy    = 1'b0;
        bus.row_start   = 1'b0;
        bus.h_mcu       = '0;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        clr();
        step();
        rst = 1'b0;
        @(negedge clk);
        err_exp = 1'b0;
        done_q.delete();
    endtask

    // Expected grants/indices come from the closed-form MCU period, not a state machine.
    task automatic run_row(input int h, input int hold, input int done_off,
                           input int dup_off, input int hb_off);
        int n, f, d, k, m, bad, ey, ecb, ecr;
        logic [2:0] ee;
        logic eb;
        string msg;
        n = cyc + 1;
        f = n + 1 + hold;
        d = n + done_off;
        bad = 0;
        msg = "";
        for (int t = n; t <= d + 1; t++) begin
            step();
            bus.row_start = (t == n) || (dup_off != 0 && t == n + dup_off);
            bus.h_mcu     = (t == n) ? XW'(h) : XW'(3);
            bus.hdr_busy  = (t < n + hold) || (hb_off != 0 && t == n + hb_off);
            if (t == n) done_q.push_back(d);
            @(negedge clk);
            ee = 3'b000; ey = 0; ecb = 0; ecr = 0;
            eb = (h > 0 && t > n && t < d);
            if (h > 0 && t >= f && t <= d) begin
                k = (t - f) / P;
                m = (t - f) % P;
                if (t < d) ee = (m < TH_Y) ? 3'b001 : (m < TH_Y + TH_C) ? 3'b010 :
                                (m < TH_Y + 2 * TH_C) ? 3'b100 : 3'b000;
                ey  = k + ((m >= TH_Y) ? 1 : 0);
                ecb = k + ((m >= TH_Y + TH_C) ? 1 : 0);
                ecr = k + ((m >= TH_Y + 2 * TH_C) ? 1 : 0);
            end
            if (bus.ereq !== ee || bus.busy !== eb || bus.ex_y !== XW'(ey) ||
                bus.ex_cb !== XW'(ecb) || bus.ex_cr !== XW'(ecr) ||
                bus.err_overrun !== err_exp || $countones(bus.ereq) > 1) begin
                bad++;
                if (msg == "")
                    msg = $sformatf("t-n=%0d ereq=%b/%b busy=%b/%b ex=%0d,%0d,%0d/%0d,%0d,%0d err=%b/%b",
                                    t - n, bus.ereq, ee, bus.busy, eb, bus.ex_y, bus.ex_cb, bus.ex_cr,
                                    ey, ecb, ecr, bus.err_overrun, err_exp);
            end
            if (bus.row_done === 1'b1) begin
                if (done_q.size() == 0) chk("row_done_spurious", bus.row_done, 0);
                else chk("row_done_cycle", t, done_q.pop_front());
            end
            if ((dup_off != 0 && t == n + dup_off) || (hb_off != 0 && t == n + hb_off))
                err_exp = 1'b1;
        end
        clr();
        chk($sformatf("row_h%0d_bad_cycles", h), bad, 0);
        if (bad != 0) $display("  first bad cycle: %s", msg);
        chk("row_done_missing", done_q.size(), 0);
        done_q.delete();
    endtask

    initial begin
        int n, seen;
        tbl[0] = '{h: 2, hold: 0,  done_off: 97};
        tbl[1] = '{h: 0, hold: 0,  done_off: 1};
        tbl[2] = '{h: 1, hold: 11, done_off: 60};
        tbl[3] = '{h: 3, hold: 0,  done_off: 145};
        tbl[4] = '{h: 1, hold: 3,  done_off: 52};
        cyc = 0; n_cmp = 0; n_bad = 0; err_exp = 1'b0;
        rst = 1'b1;
        clr();
        do_reset();

        chk("reset_ereq", bus.ereq, 0);
        chk("reset_ex_y", bus.ex_y, 0);
        chk("reset_ex_cb", bus.ex_cb, 0);
        chk("reset_ex_cr", bus.ex_cr, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_row_done", bus.row_done, 0);
        chk("reset_err", bus.err_overrun, 0);

        step(); bus.frame_start = 1'b1;
        step(); bus.frame_start = 1'b0;
        @(negedge clk);
        chk("idle_frame_start_err", bus.err_overrun, 0);
        chk("idle_frame_start_busy", bus.busy, 0);

        step(); bus.frame_start = 1'b1; bus.row_start = 1'b1; bus.h_mcu = 8'd2;
        step(); clr();
        @(negedge clk);
        chk("fs_rs_busy", bus.busy, 0);
        chk("fs_rs_ereq", bus.ereq, 0);
        chk("fs_rs_err", bus.err_overrun, 0);

        for (int i = 0; i < 5; i++) run_row(tbl[i].h, tbl[i].hold, tbl[i].done_off, 0, 0);

        run_row(2, 0, 97, 20, 0);
        do_reset();
        chk("rst_clears_err", bus.err_overrun, 0);
        run_row(1, 0, 49, 0, 5);

        do_reset();
        n = cyc + 1;
        seen = 0;
        for (int t = n; t <= n + 90; t++) begin
            step();
            bus.row_start   = (t == n);
            bus.h_mcu       = 8'd2;
            bus.frame_start = (t == n + 30);
            @(negedge clk);
            if (bus.row_done === 1'b1) seen++;
            if (t == n + 30) chk("abort_pre_ex_y", bus.ex_y, 1);
            if (t == n + 31) begin
                chk("abort_ereq", bus.ereq, 0);
                chk("abort_ex_y", bus.ex_y, 0);
                chk("abort_ex_cb", bus.ex_cb, 0);
                chk("abort_ex_cr", bus.ex_cr, 0);
                chk("abort_busy", bus.busy, 0);
                chk("abort_err", bus.err_overrun, 1);
            end
        end
        clr();
        chk("abort_no_row_done", seen, 0);

        do_reset();
        n = cyc + 1;
        for (int t = n; t <= n + 33; t++) begin
            step();
            bus.row_start = (t == n) || (t == n + 5);
            bus.h_mcu     = 8'd2;
            rst           = (t == n + 32);
            @(negedge clk);
            if (t == n + 32) begin
                chk("cb_pre_ereq", bus.ereq, 2);
                chk("cb_pre_err", bus.err_overrun, 1);
            end
            if (t == n + 33) begin
                chk("rst_mid_ereq", bus.ereq, 0);
                chk("rst_mid_ex_y", bus.ex_y, 0);
                chk("rst_mid_busy", bus.busy, 0);
                chk("rst_mid_row_done", bus.row_done, 0);
                chk("rst_mid_err", bus.err_overrun, 0);
            end
        end
        clr();
        err_exp = 1'b0;
        run_row(255, 0, 255 * P + 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
